// File: rtl/fetch_prefetch_ctrl.sv
// fetch_prefetch_ctrl: credit-based instruction fetch sequencer feeding the prefetch FIFO, with flush/discard handling
module fetch_prefetch_ctrl #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          MAX_OST    = 2,
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        flush_req,
  input  logic [31:0] flush_addr,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_gnt,
  input  logic        instr_rvalid,
  input  logic [31:0] instr_rdata,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_data,
  output logic        fifo_clear,
  input  logic        fifo_rd_en,
  output logic        busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d, addr_q;
  logic [CW-1:0] ost_q, ost_d, disc_q, disc_d, occ_q, occ_d;
  logic          req_q, stale_q, stale_d;
  logic          issue, gnt, pend, rv, pop;
  // Bus handshake and FIFO-side outputs; a raised request is replayed from req_q/addr_q until granted
  always_comb begin
    issue        = (state_q == RUN) && (ost_q < CW'(MAX_OST)) &&
                   (({1'b0, occ_q} + {1'b0, ost_q}) < (CW+1)'(FIFO_DEPTH));
    instr_req    = req_q | issue;
    instr_addr   = req_q ? addr_q : pc_q;
    gnt          = instr_req & instr_gnt;
    pend         = instr_req & ~instr_gnt;
    rv           = instr_rvalid & (ost_q != '0);
    fifo_wr_en   = rv & ~flush_req & (disc_q == '0);
    fifo_wr_data = fifo_wr_en ? instr_rdata : '0;
    fifo_clear   = flush_req & ~reset;
    pop          = fifo_rd_en & (occ_q != '0);
    busy         = (ost_q != '0) || (disc_q != '0);
  end
  // Next-state: a stale request (raised before a flush) completes at its old address and is discarded on return
  always_comb begin
    ost_d   = ost_q + CW'(gnt) - CW'(rv);
    pc_d    = flush_req ? flush_addr : (gnt & ~stale_q) ? pc_q + 32'd4 : pc_q;
    occ_d   = flush_req ? '0 : occ_q + CW'(fifo_wr_en) - CW'(pop);
    stale_d = flush_req ? pend : stale_q & ~gnt;
    disc_d  = flush_req ? ost_d : disc_q - CW'(rv & (disc_q != '0)) + CW'(gnt & stale_q);
    state_d = flush_req ? ((ost_d != '0 || stale_d) ? DRAIN : fetch_enable ? RUN : IDLE) :
              state_q == IDLE ? (fetch_enable ? RUN : IDLE) :
              state_q == RUN  ? ((!fetch_enable && !pend) ? IDLE : RUN) :
              (disc_d == '0 && !stale_d) ? (fetch_enable ? RUN : IDLE) : DRAIN;
  end
  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= BOOT_ADDR;
      addr_q  <= BOOT_ADDR;
      ost_q   <= '0;
      disc_q  <= '0;
      occ_q   <= '0;
      req_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= instr_addr;
      ost_q   <= ost_d;
      disc_q  <= disc_d;
      occ_q   <= occ_d;
      req_q   <= pend;
      stale_q <= stale_d;
    end
  end
endmodule
